// File: rtl/pio_sm_core.sv
// pio_sm_core: small programmable-I/O state machine core.
// Executes 16-bit instructions from a local memory. Each instruction holds
// an opcode, a delay, an argument and a data field. JMP, WAIT and SET do work;
// every other opcode is a NOP. The stalled output is high while a WAIT is
// blocking or a post-instruction delay is counting down.
module pio_sm_core #(
  parameter int ADDR_W   = 5,
  parameter int REG_W    = 8,
  parameter int NUM_PINS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                restart,
  input  logic [ADDR_W-1:0]   wrap_bottom,
  input  logic [ADDR_W-1:0]   wrap_top,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [15:0]         wr_data,
  input  logic [NUM_PINS-1:0] in_pins,
  output logic [ADDR_W-1:0]   pc,
  output logic [REG_W-1:0]    x,
  output logic [REG_W-1:0]    y,
  output logic [NUM_PINS-1:0] out_pins,
  output logic                stalled,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_SET  = 3'b111;

  typedef enum logic [1:0] {
    S_EXEC  = 2'd0,
    S_WAIT  = 2'd1,
    S_DELAY = 2'd2
  } state_t;

  logic [15:0]         r_mem [DEPTH];
  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [REG_W-1:0]    r_x;
  logic [REG_W-1:0]    r_y;
  logic [NUM_PINS-1:0] r_out;
  logic [4:0]          r_dly;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [REG_W-1:0]    w_x_nxt;
  logic [REG_W-1:0]    w_y_nxt;
  logic [NUM_PINS-1:0] w_out_nxt;
  logic [4:0]          w_dly_nxt;

  logic [15:0]         w_instr;
  logic [2:0]          w_op;
  logic [4:0]          w_delay;
  logic [2:0]          w_arg;
  logic [4:0]          w_data;
  logic [ADDR_W-1:0]   w_pc_seq;
  logic [ADDR_W-1:0]   w_pc_tgt;
  logic [31:0]         w_pins_ext;
  logic                w_wait_pin;
  logic                w_jmp_cond;
  logic                w_done;

  // Instruction is read combinationally, so a same-edge write is seen next cycle.
  assign w_instr = r_mem[r_pc];
  assign w_op    = w_instr[15:13];
  assign w_delay = w_instr[12:8];
  assign w_arg   = w_instr[7:5];
  assign w_data  = w_instr[4:0];

  // Only the exact wrap_top match wraps, so bottom > top is still well defined.
  assign w_pc_seq = (r_pc == wrap_top) ? wrap_bottom : r_pc + ADDR_W'(1);

  // Pins above NUM_PINS are zero in the widened copy, so any index reads 0.
  assign w_pins_ext = 32'(in_pins);
  assign w_wait_pin = w_pins_ext[w_data];

  assign pc        = r_pc;
  assign x         = r_x;
  assign y         = r_y;
  assign out_pins  = r_out;
  assign stalled   = (r_state == S_WAIT) || (r_state == S_DELAY);
  assign dbg_state = r_state;

  // Evaluate the JMP condition from the pre-decrement register values.
  always_comb begin
    w_jmp_cond = 1'b0;
    case (w_arg)
      3'b000:  w_jmp_cond = 1'b1;
      3'b001:  w_jmp_cond = (r_x == '0);
      3'b010:  w_jmp_cond = (r_x != '0);
      3'b011:  w_jmp_cond = (r_y == '0);
      3'b100:  w_jmp_cond = (r_y != '0);
      3'b101:  w_jmp_cond = (r_x != r_y);
      3'b110:  w_jmp_cond = in_pins[0];
      default: w_jmp_cond = 1'b0;
    endcase
  end

  // Next-state logic. Restart beats execution, and en low holds everything.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_out_nxt   = r_out;
    w_dly_nxt   = r_dly;
    w_pc_tgt    = w_pc_seq;
    w_done      = 1'b0;
    if (restart) begin
      w_state_nxt = S_EXEC;
      w_pc_nxt    = wrap_bottom;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_dly_nxt   = '0;
    end else if (en) begin
      if (r_state == S_DELAY) begin
        if (r_dly <= 5'd1) begin
          w_state_nxt = S_EXEC;
          w_dly_nxt   = '0;
        end else begin
          w_dly_nxt = r_dly - 5'd1;
        end
      end else begin
        // EXEC runs the instruction. WAIT re-runs the held instruction.
        w_done = 1'b1;
        case (w_op)
          OP_JMP: begin
            if (w_jmp_cond) w_pc_tgt = w_data[ADDR_W-1:0];
            if (w_arg == 3'b010) w_x_nxt = r_x - REG_W'(1);
            if (w_arg == 3'b100) w_y_nxt = r_y - REG_W'(1);
          end
          OP_WAIT: w_done = (w_wait_pin == w_arg[2]);
          OP_SET: begin
            case (w_arg)
              3'b000:  w_out_nxt = NUM_PINS'(w_data);
              3'b001:  w_x_nxt   = REG_W'(w_data);
              3'b010:  w_y_nxt   = REG_W'(w_data);
              default: ;
            endcase
          end
          default: ;
        endcase
        if (w_done) begin
          w_pc_nxt = w_pc_tgt;
          if (w_delay != 5'd0) begin
            w_state_nxt = S_DELAY;
            w_dly_nxt   = w_delay;
          end else begin
            w_state_nxt = S_EXEC;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
    end
  end

  // Execution state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EXEC;
      r_pc    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_out   <= '0;
      r_dly   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_out   <= w_out_nxt;
      r_dly   <= w_dly_nxt;
    end
  end

  // Instruction memory. It clears on reset and accepts writes whatever en is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_pio_sm_core.sv
// Testbench for pio_sm_core. It runs directed program scenarios and then
// randomized programs. Every cycle it checks the outputs against a reference
// model that re-executes the instruction semantics at instruction level.
module tb_pio_sm_core;

  localparam int AW    = 5;
  localparam int RW    = 8;
  localparam int NP    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int RMASK = (1 << RW) - 1;
  localparam int PMASK = (1 << NP) - 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic          restart;
  logic [AW-1:0] wrap_bottom;
  logic [AW-1:0] wrap_top;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [NP-1:0] in_pins;
  logic [AW-1:0] pc;
  logic [RW-1:0] x;
  logic [RW-1:0] y;
  logic [NP-1:0] out_pins;
  logic          stalled;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: a WAIT that has not been met is simply re-executed
  // every enabled cycle, and a delay is a count of stall cycles left.
  int unsigned m_mem [DEPTH];
  int unsigned m_pc, m_x, m_y, m_out, m_stall;
  bit          m_waiting;

  pio_sm_core #(.ADDR_W(AW), .REG_W(RW), .NUM_PINS(NP)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .wrap_bottom(wrap_bottom), .wrap_top(wrap_top),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_pins(in_pins), .pc(pc), .x(x), .y(y), .out_pins(out_pins),
    .stalled(stalled), .dbg_state(dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_pc = 0; m_x = 0; m_y = 0; m_out = 0; m_stall = 0; m_waiting = 0;
  endtask

  // One rising edge worth of behaviour, computed from the pre-edge inputs.
  task automatic model_clock();
    int unsigned ins, op, dly, arg, dat, nxt, pin;
    bit cond, done;
    ins = m_mem[m_pc];
    if (restart) begin
      m_pc = wrap_bottom; m_x = 0; m_y = 0; m_stall = 0; m_waiting = 0;
    end else if (en) begin
      if (m_stall > 0) begin
        m_stall = m_stall - 1;
      end else begin
        op  = ins >> 13;
        dly = (ins >> 8) & 31;
        arg = (ins >> 5) & 7;
        dat = ins & 31;
        nxt = (m_pc == wrap_top) ? wrap_bottom : (m_pc + 1) % DEPTH;
        done = 1;
        cond = 0;
        if (op == 0) begin
          case (arg)
            0: cond = 1;
            1: cond = (m_x == 0);
            2: begin cond = (m_x != 0); m_x = (m_x == 0) ? RMASK : m_x - 1; end
            3: cond = (m_y == 0);
            4: begin cond = (m_y != 0); m_y = (m_y == 0) ? RMASK : m_y - 1; end
            5: cond = (m_x != m_y);
            6: cond = in_pins[0];
            default: cond = 0;
          endcase
          if (cond) nxt = dat % DEPTH;
        end else if (op == 1) begin
          pin  = (dat < NP) ? ((int'(in_pins) >> dat) & 1) : 0;
          done = (pin == (arg >> 2));
        end else if (op == 7) begin
          if (arg == 0) m_out = dat & PMASK;
          if (arg == 1) m_x   = dat & RMASK;
          if (arg == 2) m_y   = dat & RMASK;
        end
        if (done) begin
          m_pc = nxt; m_stall = dly; m_waiting = 0;
        end else begin
          m_waiting = 1;
        end
      end
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
  endtask

  task automatic check_model();
    chk("pc", pc, m_pc);
    chk("x", x, m_x);
    chk("y", y, m_y);
    chk("out_pins", out_pins, m_out);
    chk("stalled", stalled, (m_waiting || m_stall > 0) ? 1 : 0);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_model();
  endtask

  task automatic load(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic set_wrap(input int b, input int t);
    wrap_bottom = AW'(b); wrap_top = AW'(t);
  endtask

  int exp35_pc [5] = '{1, 1, 1, 1, 0};
  int exp35_x  [5] = '{3, 2, 1, 0, 255};
  int exp36_pc [6] = '{3, 4, 2, 3, 4, 2};

  initial begin
    rst = 1'b0; en = 1'b0; restart = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; in_pins = '0;
    wrap_bottom = '0; wrap_top = '0;
    model_reset();
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_x", x, 0);
    chk("rst_out", out_pins, 0);
    chk("rst_stalled", stalled, 0);
    rst = 1'b1;

    // Reset memory decodes as JMP-always-to-0, so pc stays at 0.
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); chk("idle_pc", pc, 0); end

    // Countdown loop: SET X=3, then JMP X-- back to itself.
    en = 1'b0;
    load(0, 16'hE023);
    load(1, 16'h0041);
    set_wrap(0, 1);
    do_restart();
    en = 1'b1;
    chk("r35_pc0", pc, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r35_pc", pc, exp35_pc[i]);
      chk("r35_x", x, exp35_x[i]);
    end

    // NOPs that wrap from 4 back to 2.
    en = 1'b0;
    for (int a = 2; a <= 4; a++) load(a, 16'h4000);
    set_wrap(2, 4);
    do_restart();
    en = 1'b1;
    chk("r36_pc0", pc, 2);
    for (int i = 0; i < 6; i++) begin step(); chk("r36_pc", pc, exp36_pc[i]); end

    // WAIT for pin 1 to go high.
    en = 1'b0;
    load(5, 16'h2081);
    load(6, 16'h4000);
    set_wrap(5, 6);
    do_restart();
    in_pins = '0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r37_stall", stalled, 1);
      chk("r37_pc", pc, 5);
    end
    in_pins = 8'h02;
    step();
    chk("r37_done_pc", pc, 6);
    chk("r37_done_stall", stalled, 0);

    // SET pins with delay 3, then SET X=5.
    en = 1'b0;
    in_pins = '0;
    load(7, 16'hE315);
    load(8, 16'hE025);
    set_wrap(7, 8);
    do_restart();
    en = 1'b1;
    step();
    chk("r38_out", out_pins, 8'h15);
    chk("r38_stall1", stalled, 1);
    step(); chk("r38_stall2", stalled, 1);
    step(); chk("r38_stall3", stalled, 1);
    step(); chk("r38_stall4", stalled, 0); chk("r38_x4", x, 0);
    step(); chk("r38_x5", x, 5); chk("r38_pc5", pc, 7);

    // Freeze mid-delay with en low, then restart.
    step();
    chk("r39_stall", stalled, 1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r39_frz_pc", pc, 8);
      chk("r39_frz_x", x, 5);
      chk("r39_frz_stall", stalled, 1);
    end
    do_restart();
    chk("r39_pc", pc, 7);
    chk("r39_x", x, 0);
    chk("r39_out", out_pins, 8'h15);
    chk("r39_stall", stalled, 0);

    // Asynchronous reset while blocked in WAIT.
    set_wrap(5, 6);
    do_restart();
    en = 1'b1;
    step();
    chk("r40_pre_stall", stalled, 1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("r40_pc", pc, 0);
    chk("r40_x", x, 0);
    chk("r40_y", y, 0);
    chk("r40_out", out_pins, 0);
    chk("r40_stall", stalled, 0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); chk("r40_mem0_pc", pc, 0); end

    // Randomized programs checked against the model every cycle.
    for (int blk = 0; blk < 3; blk++) begin
      en = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 2) != 0) w[12:8] = 5'($urandom_range(0, 2));
        load(a, w);
      end
      set_wrap($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      do_restart();
      for (int c = 0; c < 600; c++) begin
        en      = ($urandom_range(0, 7) != 0);
        restart = ($urandom_range(0, 63) == 0);
        in_pins = NP'($urandom);
        wr_en   = ($urandom_range(0, 15) == 0);
        wr_addr = AW'($urandom);
        wr_data = 16'($urandom);
        step();
      end
      restart = 1'b0;
      wr_en   = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
